// File: rtl/board_run_if.sv
// Board-side control bus of the run controller: raw pins and loader status in, CPU/loader controls out.
interface board_run_if;
  logic [4:0] btn_raw;
  logic [2:0] sw_mode;
  logic       uart_done;
  logic       cpu_rst;
  logic       cpu_clk_en;
  logic       uart_start;
  logic [4:0] btn_pulse;
  logic [2:0] state_o;

  // uart_start/uart_done are a pulse handshake: a single-cycle uart_start launches one program
  // load, and the loader answers with a single-cycle uart_done, honoured only while in LOAD.
  modport master (
    output btn_raw, sw_mode, uart_done,
    input  cpu_rst, cpu_clk_en, uart_start, btn_pulse, state_o
  );

  modport slave (
    input  btn_raw, sw_mode, uart_done,
    output cpu_rst, cpu_clk_en, uart_start, btn_pulse, state_o
  );
endinterface

// File: rtl/board_run_controller.sv
// Run-mode sequencer for the Minisys CPU: debounces board buttons, decodes the mode switches
// and drives CPU reset, clock enable and the UART program-load start.
module board_run_controller #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int RST_HOLD_CYCLES = 4,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  board_run_if.slave bus
);
  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_STEP   = 3'd3;
  localparam logic [2:0] S_LOAD   = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYCLES - 1);

  logic [4:0]       btn_s1, btn_s2, level, level_d, btn_pulse;
  logic [2:0]       mode_s1, mode_s2, mode_q;
  logic [2:0]       state, next_state;
  logic [CNT_W-1:0] hold_cnt;
  logic             load_done, set_done, clr_done, mode_chg, step_fire;
  logic             cpu_rst, cpu_clk_en, uart_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1  <= '0;
      btn_s2  <= '0;
      mode_s1 <= '0;
      mode_s2 <= '0;
    end else begin
      btn_s1  <= bus.btn_raw;
      btn_s2  <= btn_s1;
      mode_s1 <= bus.sw_mode;
      mode_s2 <= mode_s1;
    end
  end

  // A new level is accepted only after DEBOUNCE_CYCLES consecutive samples disagree with it.
  for (genvar i = 0; i < 5; i++) begin : g_db
    logic [CNT_W-1:0] cnt;
    logic             lvl;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (btn_s2[i] == lvl) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        cnt <= '0;
        lvl <= btn_s2[i];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign level[i] = lvl;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_d   <= '0;
      btn_pulse <= '0;
    end else begin
      level_d   <= level;
      btn_pulse <= level & ~level_d;
    end
  end

  always_comb begin
    next_state = state;
    set_done   = 1'b0;
    clr_done   = 1'b0;
    mode_chg   = (mode_s2 != mode_q);
    if (state == S_RESET) begin
      if (hold_cnt == HOLD_LAST) next_state = S_DECODE;
    end else if (btn_pulse[3] || mode_chg) begin
      next_state = S_RESET;
      clr_done   = mode_chg;
    end else begin
      case (state)
        S_DECODE: begin
          case (mode_q)
            3'b001:  next_state = S_RUN;
            3'b010:  next_state = S_STEP;
            3'b100:  next_state = load_done ? S_HALT : S_LOAD;
            default: next_state = S_HALT;
          endcase
        end
        S_LOAD: begin
          if (bus.uart_done) begin
            next_state = S_RESET;
            set_done   = 1'b1;
          end
        end
        default: next_state = state;
      endcase
    end
  end

  // Step pulses only count while STEP is held; a coincident restart wins and drops them.
  assign step_fire = (state == S_STEP) && (next_state == S_STEP) && btn_pulse[4];

  // Outputs are registered from the next state so they stay aligned with state_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_RESET;
      hold_cnt   <= '0;
      mode_q     <= '0;
      load_done  <= 1'b0;
      cpu_rst    <= 1'b1;
      cpu_clk_en <= 1'b0;
      uart_start <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_RESET && next_state == S_RESET) hold_cnt <= hold_cnt + 1'b1;
      else hold_cnt <= '0;
      if (state == S_RESET) mode_q <= mode_s2;
      if (clr_done) load_done <= 1'b0;
      else if (set_done) load_done <= 1'b1;
      cpu_rst    <= (next_state == S_RESET) || (next_state == S_LOAD);
      cpu_clk_en <= (next_state == S_RUN) || step_fire;
      uart_start <= (next_state == S_LOAD) && (state != S_LOAD);
    end
  end

  assign bus.cpu_rst    = cpu_rst;
  assign bus.cpu_clk_en = cpu_clk_en;
  assign bus.uart_start = uart_start;
  assign bus.btn_pulse  = btn_pulse;
  assign bus.state_o    = state;
endmodule
